avalon_gpio_pio: RTL and testbench
==================================

Name: avalon_gpio_pio

Overview:
Parametrised Avalon-MM slave general-purpose I/O port. It is the next generation of the subsystem output-only PIO.
- Adds: configurable width, per-bit direction control, input synchronisation, edge capture, masked interrupt, and atomic set/clear/toggle of the output register.
- Sits on the subsystem Avalon bus: drives LEDs/enables and samples switches/status lines.

Parameters:
DATA_WIDTH, 8, port width in bits, legal 1..32
RESET_OUT, 0, reset value of output data register (DATA_WIDTH bits)
RESET_DIR, 0, reset value of direction register (1 = output)
SYNC_STAGES, 2, input synchroniser depth, legal 2..4
EDGE_MODE, 0, edge that sets capture bits: 0 rising, 1 falling, 2 any

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
address  in  3  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, zero wait states, combinational from registers
gpio_in  in  DATA_WIDTH  asynchronous external inputs
gpio_out  out  DATA_WIDTH  output data register
gpio_oe  out  DATA_WIDTH  direction register, 1 = drive pad
irq  out  1  level interrupt, active-high

Behaviour:
- Write strobe: wr = chipselect & ~write_n. Register updates occur on the posedge clk following wr.
- Register map:
  - 0 DATA: read = per bit oe ? data_out : sync_in; write loads data_out.
  - 1 DIR: read/write direction register.
  - 2 IRQMASK: read/write interrupt mask register.
  - 3 EDGECAP: read capture bits; write 1 clears the bit, 0 leaves it.
  - 4 OUTSET: data_out |= wd.
  - 5 OUTCLR: data_out &= ~wd.
  - 6 OUTTGL: data_out ^= wd.
  - 7 reserved.
- Reads of 4..7 return 0. Writes to 7 are ignored.
- Only writedata[DATA_WIDTH-1:0] is used. readdata bits above DATA_WIDTH are 0.
- Reset values: data_out = RESET_OUT, dir = RESET_DIR, mask = 0, edgecap = 0, synchroniser and edge history flops = 0, irq = 0.
- Synchroniser: SYNC_STAGES flop chain per bit. sync_in = last stage. prev = sync_in delayed one cycle.
- Edge detect per bit:
  - rise = sync_in & ~prev
  - fall = ~sync_in & prev
  - EDGE_MODE selects rise, fall, or rise|fall.
  - Edge detection runs on all bits regardless of direction.
- Latency: a gpio_in transition is visible in DATA reads after SYNC_STAGES clk edges. The matching edgecap bit sets on the edge after that (SYNC_STAGES+1).
- edgecap bit, once set, holds until cleared by an EDGECAP write.
- Simultaneous edge and clear on the same bit in the same cycle: bit ends set, so no event is lost.
- irq = |(edgecap & mask), combinational from registers, so it updates in the same cycle as the register change.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Pending edges are discarded. The first synchronised 1 after reset produces a rise edge.
- chipselect low: no state change from bus inputs. readdata is still driven by address decode.

Decomposition:
- Package avalon_gpio_pkg: register address localparams ADDR_DATA=0 .. ADDR_OUTTGL=6, and EDGE_MODE encodings EDGE_RISE/EDGE_FALL/EDGE_ANY.
- Sub-module gpio_sync_edge: synchroniser chain, prev flop, and edge select. Parameters DATA_WIDTH, SYNC_STAGES, EDGE_MODE. Outputs sync_in and edge_pulse.
- Top level contains the bus decode, data/dir/mask/edgecap registers, and irq.

Test Plan:
- Reset with RESET_OUT=8'hA5, RESET_DIR=8'hFF -> gpio_out=A5, gpio_oe=FF, irq=0; read addr0 = 000000A5.
- Write addr0=3C, then addr4=C0, addr5=0C, addr6=FF -> gpio_out sequence 3C, FC, F0, 0F; read addr0 after DIR=FF returns 0000000F.
- DIR=00, gpio_in=8'h5A, wait 2 cycles -> addr0 reads 5A. Change gpio_in and read at SYNC_STAGES-1 cycles -> old value still read.
- EDGE_MODE=0, mask=01, gpio_in[0] 0->1 -> edgecap=01 and irq=1 at cycle 3. Write addr3=01 -> irq=0. gpio_in[0] 1->0 -> no capture.
- Drive a rise on bit2 in the same cycle as an addr3=04 clear write -> edgecap[2] remains 1.
- Assert reset_n low mid-cycle with edgecap=FF -> edgecap=0 and irq=0 asynchronously. Reads of addr7 and writes to addr7 have no effect and return 0.

Source files
------------

// File: rtl/avalon_gpio_pkg.sv
// Register map and edge-mode encodings shared by the Avalon GPIO PIO and its
// input synchroniser.
package avalon_gpio_pkg;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
   localparam logic [2:0] ADDR_OUTTGL  = 3'd6;
   localparam logic [2:0] ADDR_RSVD    = 3'd7;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-bit input synchroniser with a one-cycle history flop and a selectable
// edge detector feeding the edge-capture register.
module gpio_sync_edge
   import avalon_gpio_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = EDGE_RISE
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] gpio_in,
   output logic [DATA_WIDTH-1:0] sync_in,
   output logic [DATA_WIDTH-1:0] edge_pulse
);

   logic [DATA_WIDTH-1:0] syncChain_q [SYNC_STAGES];
   logic [DATA_WIDTH-1:0] prev_q;
   logic [DATA_WIDTH-1:0] riseEdge;
   logic [DATA_WIDTH-1:0] fallEdge;

   // History flop clears with the chain, so the first synchronised 1 after
   // reset is reported as a rising edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            syncChain_q[i] <= '0;
         end
         prev_q <= '0;
      end else begin
         syncChain_q[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            syncChain_q[i] <= syncChain_q[i-1];
         end
         prev_q <= syncChain_q[SYNC_STAGES-1];
      end
   end

   assign sync_in  = syncChain_q[SYNC_STAGES-1];
   assign riseEdge = sync_in & ~prev_q;
   assign fallEdge = ~sync_in & prev_q;

   always_comb begin
      edge_pulse = riseEdge;
      case (EDGE_MODE)
         EDGE_FALL: edge_pulse = fallEdge;
         EDGE_ANY:  edge_pulse = riseEdge | fallEdge;
         default:   edge_pulse = riseEdge;
      endcase
   end

endmodule

// File: rtl/avalon_gpio_pio.sv
// Avalon-MM GPIO port: data/direction/mask/edge-capture registers with atomic
// set/clear/toggle of the output register and a masked level interrupt.
module avalon_gpio_pio
   import avalon_gpio_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_OUT   = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_DIR   = '0,
   parameter int                    SYNC_STAGES = 2,
   parameter int                    EDGE_MODE   = EDGE_RISE
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [DATA_WIDTH-1:0] gpio_in,
   output logic [DATA_WIDTH-1:0] gpio_out,
   output logic [DATA_WIDTH-1:0] gpio_oe,
   output logic                  irq
);

   logic                  wr;
   logic [DATA_WIDTH-1:0] wd;
   logic                  unusedWriteBits;

   logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
   logic [DATA_WIDTH-1:0] dir_q,     dir_d;
   logic [DATA_WIDTH-1:0] mask_q,    mask_d;
   logic [DATA_WIDTH-1:0] edgeCap_q, edgeCap_d;
   logic [DATA_WIDTH-1:0] edgeClr;
   logic [DATA_WIDTH-1:0] syncIn;
   logic [DATA_WIDTH-1:0] edgePulse;
   logic [DATA_WIDTH-1:0] rdVal;

   assign wr              = chipselect & ~write_n;
   assign wd              = writedata[DATA_WIDTH-1:0];
   assign unusedWriteBits = ^writedata;

   gpio_sync_edge #(
      .DATA_WIDTH (DATA_WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_MODE  (EDGE_MODE)
   ) u_syncEdge (
      .clk       (clk),
      .reset_n   (reset_n),
      .gpio_in   (gpio_in),
      .sync_in   (syncIn),
      .edge_pulse(edgePulse)
   );

   // OR-ing the new edge in after the clear keeps an event that lands in the
   // same cycle as a software acknowledge.
   always_comb begin
      dataOut_d = dataOut_q;
      dir_d     = dir_q;
      mask_d    = mask_q;
      edgeClr   = '0;
      if (wr) begin
         case (address)
            ADDR_DATA:    dataOut_d = wd;
            ADDR_DIR:     dir_d     = wd;
            ADDR_IRQMASK: mask_d    = wd;
            ADDR_EDGECAP: edgeClr   = wd;
            ADDR_OUTSET:  dataOut_d = dataOut_q | wd;
            ADDR_OUTCLR:  dataOut_d = dataOut_q & ~wd;
            ADDR_OUTTGL:  dataOut_d = dataOut_q ^ wd;
            default:      ;
         endcase
      end
      edgeCap_d = (edgeCap_q & ~edgeClr) | edgePulse;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dataOut_q <= RESET_OUT;
         dir_q     <= RESET_DIR;
         mask_q    <= '0;
         edgeCap_q <= '0;
      end else begin
         dataOut_q <= dataOut_d;
         dir_q     <= dir_d;
         mask_q    <= mask_d;
         edgeCap_q <= edgeCap_d;
      end
   end

   always_comb begin
      rdVal = '0;
      case (address)
         ADDR_DATA:    rdVal = (dir_q & dataOut_q) | (~dir_q & syncIn);
         ADDR_DIR:     rdVal = dir_q;
         ADDR_IRQMASK: rdVal = mask_q;
         ADDR_EDGECAP: rdVal = edgeCap_q;
         default:      rdVal = '0;
      endcase
   end

   assign readdata = 32'(rdVal);
   assign gpio_out = dataOut_q;
   assign gpio_oe  = dir_q;
   assign irq      = |(edgeCap_q & mask_q);

endmodule

// File: tb/tb_avalon_gpio_pio.sv
// Table-driven bench for avalon_gpio_pio with a scoreboard queue of expected
// values, plus hand-written sequences for synchroniser and edge-capture timing.
module tb_avalon_gpio_pio;
   import avalon_gpio_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [7:0]  gpio_in = '0;
   logic [7:0]  gpio_out;
   logic [7:0]  gpio_oe;
   logic        irq;

   always #5 clk = ~clk;

   avalon_gpio_pio #(
      .DATA_WIDTH (8),
      .RESET_OUT  (8'hA5),
      .RESET_DIR  (8'hFF),
      .SYNC_STAGES(2),
      .EDGE_MODE  (EDGE_RISE)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out),
      .gpio_oe   (gpio_oe),
      .irq       (irq)
   );

   typedef struct {
      string       name;
      logic [31:0] expVal;
   } sbEntry_t;

   typedef struct {
      logic        cs;
      logic [2:0]  wAddr;
      logic [31:0] wData;
      logic [2:0]  rAddr;
      logic [7:0]  expOut;
      logic [31:0] expRead;
   } vec_t;

   sbEntry_t sbQueue[$];
   vec_t     vecs[12];
   int       compared = 0;
   int       mismatched = 0;

   task automatic expectValue(input string name, input logic [31:0] value);
      sbEntry_t e;
      e.name   = name;
      e.expVal = value;
      sbQueue.push_back(e);
   endtask

   task automatic checkOutput(input logic [31:0] actual);
      sbEntry_t e;
      compared++;
      if (sbQueue.size() == 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard_empty: got %h with nothing expected", actual);
         return;
      end
      e = sbQueue.pop_front();
      if (actual !== e.expVal) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", e.name, actual, e.expVal);
      end
   endtask

   // Called at a negedge: drives one bus write across the next posedge.
   task automatic busWrite(input logic cs, input logic [2:0] a, input logic [31:0] d);
      chipselect = cs;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic busRead(input logic [2:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      logic [31:0] rd;
      expectValue($sformatf("vec%0d_gpio_out", idx), {24'h0, v.expOut});
      expectValue($sformatf("vec%0d_read%0d", idx, v.rAddr), v.expRead);
      busWrite(v.cs, v.wAddr, v.wData);
      checkOutput({24'h0, gpio_out});
      busRead(v.rAddr, rd);
      checkOutput(rd);
   endtask

   task automatic checkRead(input string name, input logic [2:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      expectValue(name, exp);
      busRead(a, rd);
      checkOutput(rd);
   endtask

   task automatic checkIrq(input string name, input logic exp);
      expectValue(name, {31'h0, exp});
      checkOutput({31'h0, irq});
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b1, 3'd0, 32'h0000_003C, 3'd0, 8'h3C, 32'h0000_003C};
      vecs[1]  = '{1'b1, 3'd4, 32'h0000_00C0, 3'd0, 8'hFC, 32'h0000_00FC};
      vecs[2]  = '{1'b1, 3'd5, 32'h0000_000C, 3'd4, 8'hF0, 32'h0000_0000};
      vecs[3]  = '{1'b1, 3'd6, 32'h0000_00FF, 3'd0, 8'h0F, 32'h0000_000F};
      vecs[4]  = '{1'b0, 3'd0, 32'h0000_0000, 3'd0, 8'h0F, 32'h0000_000F};
      vecs[5]  = '{1'b1, 3'd0, 32'hFFFF_FF12, 3'd0, 8'h12, 32'h0000_0012};
      vecs[6]  = '{1'b1, 3'd7, 32'h0000_00FF, 3'd7, 8'h12, 32'h0000_0000};
      vecs[7]  = '{1'b1, 3'd2, 32'h0000_0081, 3'd2, 8'h12, 32'h0000_0081};
      vecs[8]  = '{1'b1, 3'd2, 32'h0000_0000, 3'd6, 8'h12, 32'h0000_0000};
      vecs[9]  = '{1'b1, 3'd1, 32'h0000_00F0, 3'd1, 8'h12, 32'h0000_00F0};
      vecs[10] = '{1'b1, 3'd3, 32'h0000_00FF, 3'd0, 8'h12, 32'h0000_0010};
      vecs[11] = '{1'b1, 3'd1, 32'h0000_0000, 3'd5, 8'h12, 32'h0000_0000};

      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      expectValue("reset_gpio_out", 32'h0000_00A5);
      checkOutput({24'h0, gpio_out});
      expectValue("reset_gpio_oe", 32'h0000_00FF);
      checkOutput({24'h0, gpio_oe});
      checkIrq("reset_irq", 1'b0);
      checkRead("reset_read_data", 3'd0, 32'h0000_00A5);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Synchroniser latency: old value one cycle in, new value after two.
      gpio_in = 8'h5A;
      @(negedge clk);
      checkRead("sync_old_value", 3'd0, 32'h0000_0000);
      @(negedge clk);
      checkRead("sync_new_value", 3'd0, 32'h0000_005A);
      @(negedge clk);
      checkRead("edgecap_5A", 3'd3, 32'h0000_005A);
      checkIrq("irq_unmasked", 1'b0);
      busWrite(1'b1, 3'd3, 32'h0000_00FF);
      checkRead("edgecap_cleared", 3'd3, 32'h0000_0000);
      gpio_in = 8'h00;
      repeat (4) @(negedge clk);
      checkRead("fall_not_captured", 3'd3, 32'h0000_0000);

      // Masked rise on bit 0 raises irq at the third edge.
      busWrite(1'b1, 3'd2, 32'h0000_0001);
      gpio_in = 8'h01;
      repeat (2) @(negedge clk);
      checkIrq("irq_before_cap", 1'b0);
      @(negedge clk);
      checkIrq("irq_after_cap", 1'b1);
      checkRead("edgecap_bit0", 3'd3, 32'h0000_0001);
      busWrite(1'b1, 3'd3, 32'h0000_0001);
      checkIrq("irq_after_clear", 1'b0);
      checkRead("edgecap_bit0_cleared", 3'd3, 32'h0000_0000);
      gpio_in = 8'h00;
      repeat (4) @(negedge clk);
      checkRead("bit0_fall_ignored", 3'd3, 32'h0000_0000);
      checkIrq("irq_after_fall", 1'b0);

      // Clear write lands in the same cycle the bit-2 rise is captured.
      gpio_in = 8'h04;
      repeat (2) @(negedge clk);
      busWrite(1'b1, 3'd3, 32'h0000_0004);
      checkRead("edge_vs_clear_kept", 3'd3, 32'h0000_0004);
      busWrite(1'b1, 3'd3, 32'h0000_0004);
      checkRead("edge_later_cleared", 3'd3, 32'h0000_0000);

      // Asynchronous reset with every capture bit set and unmasked.
      gpio_in = 8'h00;
      repeat (4) @(negedge clk);
      busWrite(1'b1, 3'd3, 32'h0000_00FF);
      busWrite(1'b1, 3'd2, 32'h0000_00FF);
      gpio_in = 8'hFF;
      repeat (3) @(negedge clk);
      checkRead("edgecap_all", 3'd3, 32'h0000_00FF);
      checkIrq("irq_all", 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      checkIrq("async_reset_irq", 1'b0);
      expectValue("async_reset_gpio_out", 32'h0000_00A5);
      checkOutput({24'h0, gpio_out});
      checkRead("async_reset_edgecap", 3'd3, 32'h0000_0000);
      checkRead("async_reset_mask", 3'd2, 32'h0000_0000);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checkRead("post_reset_no_cap_yet", 3'd3, 32'h0000_0000);
      @(negedge clk);
      checkRead("post_reset_first_rise", 3'd3, 32'h0000_00FF);
      checkIrq("post_reset_irq_masked", 1'b0);
      checkRead("post_reset_data", 3'd0, 32'h0000_00A5);

      compared++;
      if (sbQueue.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sbQueue.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
